// File: rtl/clock_period_monitor.sv
// Measures period and high time of an asynchronous slow clock in sourceClock cycles, with lock and loss detection.
// Define CLKMON_RANGE_CHECK_EN to compile in the MIN_PERIOD/MAX_PERIOD range check driving outOfRange.
module clock_period_monitor #(
  parameter int TIMEOUT     = 2048,
  parameter int LOCK_COUNT  = 4,
  parameter int SYNC_STAGES = 2,
`ifdef CLKMON_RANGE_CHECK_EN
  parameter int MIN_PERIOD  = 90,
  parameter int MAX_PERIOD  = 110,
`endif
  localparam int W = $clog2(TIMEOUT + 1)
) (
  input  logic         sourceClock,
  input  logic         reset,
  input  logic         clkIn,
  input  logic         measureEnable,
  output logic [W-1:0] period,
  output logic [W-1:0] highTime,
  output logic         valid,
  output logic         locked,
  output logic         lost,
  output logic         outOfRange
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOST} state_t;

  localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT);
  localparam logic [3:0]   LOCK_W    = 4'(LOCK_COUNT);
`ifdef CLKMON_RANGE_CHECK_EN
  localparam logic         LOST_OOR  = 1'b1;
`else
  localparam logic         LOST_OOR  = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   delayed_reg;
  logic                   synced;
  logic                   rise_event;
  logic                   fall_event;

  state_t                 state_reg;
  logic [W-1:0]           counter_reg;
  logic [W-1:0]           period_reg;
  logic [W-1:0]           high_time_reg;
  logic [W-1:0]           high_latched_reg;
  logic                   fall_seen_reg;
  logic                   valid_reg;
  logic                   locked_reg;
  logic                   lost_reg;
  logic                   out_of_range_reg;
  logic [3:0]             match_reg;

  logic [W-1:0]           counter_next;
  logic [W-1:0]           period_next;
  logic [3:0]             match_next;
  logic                   range_bad;
  logic                   lock_next;

  always_ff @(posedge sourceClock) begin
    if (reset) begin
      sync_reg    <= '0;
      delayed_reg <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], clkIn};
      delayed_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign synced     = sync_reg[SYNC_STAGES-1];
  assign rise_event = synced & ~delayed_reg;
  assign fall_event = ~synced & delayed_reg;

  always_comb begin
    counter_next = (counter_reg == TIMEOUT_W) ? counter_reg : counter_reg + 1'b1;
    period_next  = counter_reg + 1'b1;
    if (period_next != period_reg)
      match_next = 4'd1;
    else if (match_reg == LOCK_W)
      match_next = match_reg;
    else
      match_next = match_reg + 4'd1;
`ifdef CLKMON_RANGE_CHECK_EN
    range_bad = (int'(period_next) < MIN_PERIOD) || (int'(period_next) > MAX_PERIOD);
`else
    range_bad = 1'b0;
`endif
    lock_next = (match_next == LOCK_W) && !range_bad;
  end

  always_ff @(posedge sourceClock) begin
    if (reset) begin
      state_reg        <= IDLE;
      counter_reg      <= '0;
      period_reg       <= '0;
      high_time_reg    <= '0;
      high_latched_reg <= '0;
      fall_seen_reg    <= 1'b0;
      valid_reg        <= 1'b0;
      locked_reg       <= 1'b0;
      lost_reg         <= 1'b0;
      out_of_range_reg <= 1'b0;
      match_reg        <= '0;
    end else begin
      valid_reg <= 1'b0;
      // Disable takes priority over any edge seen in the same cycle.
      if (!measureEnable) begin
        state_reg        <= IDLE;
        counter_reg      <= '0;
        fall_seen_reg    <= 1'b0;
        locked_reg       <= 1'b0;
        lost_reg         <= 1'b0;
        out_of_range_reg <= 1'b0;
        match_reg        <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            counter_reg <= '0;
            state_reg   <= ARM;
          end
          ARM: begin
            if (rise_event) begin
              counter_reg   <= '0;
              fall_seen_reg <= 1'b0;
              state_reg     <= MEASURE;
            end else begin
              counter_reg <= counter_next;
              if (counter_next == TIMEOUT_W) begin
                state_reg        <= LOST;
                lost_reg         <= 1'b1;
                locked_reg       <= 1'b0;
                match_reg        <= '0;
                out_of_range_reg <= LOST_OOR;
              end
            end
          end
          MEASURE: begin
            if (rise_event) begin
              counter_reg      <= '0;
              period_reg       <= period_next;
              high_time_reg    <= fall_seen_reg ? high_latched_reg : '0;
              fall_seen_reg    <= 1'b0;
              valid_reg        <= 1'b1;
              match_reg        <= match_next;
              locked_reg       <= lock_next;
              out_of_range_reg <= range_bad;
            end else begin
              if (fall_event) begin
                high_latched_reg <= counter_reg + 1'b1;
                fall_seen_reg    <= 1'b1;
              end
              counter_reg <= counter_next;
              if (counter_next == TIMEOUT_W) begin
                state_reg        <= LOST;
                lost_reg         <= 1'b1;
                locked_reg       <= 1'b0;
                match_reg        <= '0;
                out_of_range_reg <= LOST_OOR;
              end
            end
          end
          LOST: begin
            if (rise_event) begin
              counter_reg   <= '0;
              fall_seen_reg <= 1'b0;
              lost_reg      <= 1'b0;
              state_reg     <= MEASURE;
            end else begin
              counter_reg <= counter_next;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign period     = period_reg;
  assign highTime   = high_time_reg;
  assign valid      = valid_reg;
  assign locked     = locked_reg;
  assign lost       = lost_reg;
  assign outOfRange = out_of_range_reg;

endmodule

// File: tb/tb_clock_period_monitor.sv
// Bench for clock_period_monitor: table rows, hand sequences for timeout/reset/disable, and random clocks
// checked against a waveform-level model that derives period/high/lock from the edge times it drove.
module tb_clock_period_monitor;

  localparam int TIMEOUT     = 2048;
  localparam int LOCK_COUNT  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int W           = $clog2(TIMEOUT + 1);
`ifdef CLKMON_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic         sourceClock = 1'b0;
  logic         reset;
  logic         clkIn;
  logic         measureEnable;
  logic [W-1:0] period;
  logic [W-1:0] highTime;
  logic         valid;
  logic         locked;
  logic         lost;
  logic         outOfRange;

  always #5 sourceClock = ~sourceClock;

  clock_period_monitor #(
    .TIMEOUT     (TIMEOUT),
    .LOCK_COUNT  (LOCK_COUNT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .sourceClock   (sourceClock),
    .reset         (reset),
    .clkIn         (clkIn),
    .measureEnable (measureEnable),
    .period        (period),
    .highTime      (highTime),
    .valid         (valid),
    .locked        (locked),
    .lost          (lost),
    .outOfRange    (outOfRange)
  );

  typedef struct { int n; int h; int reps; int exp_p; int exp_h; bit exp_l; } row_t;
  typedef struct { int p; int h; bit l; bit o; } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   valid_count = 0;
  int   last_valid_cyc = 0;
  exp_t exp_q[$];

  // Model: edge times as driven by the bench
  bit   m_enabled = 1'b0;
  bit   m_armed = 1'b0;
  bit   m_fall_seen = 1'b0;
  int   m_last_rise = 0;
  int   m_last_fall = 0;
  int   m_hist[$];

  function automatic bit in_range(int p);
    if (!RANGE_EN) return 1'b1;
    return (p >= 90) && (p <= 110);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_clear();
    m_armed = 1'b0;
    m_fall_seen = 1'b0;
    m_hist.delete();
  endfunction

  function automatic void model_rise();
    int   gap;
    bit   same;
    exp_t e;
    if (!m_enabled) return;
    if (m_armed) begin
      gap = cyc - m_last_rise;
      if (gap > TIMEOUT) begin
        m_hist.delete();
      end else begin
        m_hist.push_back(gap);
        if (m_hist.size() > LOCK_COUNT) void'(m_hist.pop_front());
        same = (m_hist.size() == LOCK_COUNT);
        foreach (m_hist[i]) if (m_hist[i] != gap) same = 1'b0;
        e.p = gap;
        e.h = m_fall_seen ? (m_last_fall - m_last_rise) : 0;
        e.l = same && in_range(gap);
        e.o = RANGE_EN && !in_range(gap);
        exp_q.push_back(e);
      end
    end
    m_armed = 1'b1;
    m_last_rise = cyc;
    m_fall_seen = 1'b0;
  endfunction

  function automatic void model_fall();
    if (!m_enabled || !m_armed) return;
    m_last_fall = cyc;
    m_fall_seen = 1'b1;
  endfunction

  task automatic step();
    exp_t e;
    @(posedge sourceClock);
    #1;
    cyc++;
    if (valid) begin
      valid_count++;
      last_valid_cyc = cyc;
      $display("valid cyc=%0d period=%0d high=%0d locked=%0d oor=%0d",
               cyc, period, highTime, locked, outOfRange);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("valid_period", int'(period), e.p);
        check("valid_high", int'(highTime), e.h);
        check("valid_locked", int'(locked), int'(e.l));
        check("valid_oor", int'(outOfRange), int'(e.o));
      end
    end
  endtask

  task automatic set_clk(input logic v);
    if (v && !clkIn) model_rise();
    if (!v && clkIn) model_fall();
    clkIn = v;
  endtask

  task automatic run_cycle(input int n, input int h);
    set_clk(1'b1);
    repeat (h) step();
    set_clk(1'b0);
    repeat (n - h) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_high"}, int'(highTime), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_lost"}, int'(lost), 0);
    check({tag, "_oor"}, int'(outOfRange), 0);
  endtask

  row_t rows[8];

  initial begin
    int lost_cyc;
    int saved_p;
    int saved_h;
    int vc;
    int n;
    int h;
    int reps;

    rows[0] = '{100, 50, 6, 100, 50, 1'b1};
    rows[1] = '{100, 40, 6, 100, 40, 1'b1};
    rows[2] = '{120, 60, 6, 120, 60, 1'b1};
    rows[3] = '{ 80, 40, 6,  80, 40, 1'b1};
    rows[4] = '{  4,  2, 6,   4,  2, 1'b1};
    rows[5] = '{  5,  3, 6,   5,  3, 1'b1};
    rows[6] = '{  9,  2, 6,   9,  2, 1'b1};
    rows[7] = '{100, 50, 6, 100, 50, 1'b1};

    reset = 1'b1;
    clkIn = 1'b0;
    measureEnable = 1'b0;
    repeat (3) step();
    check_all_zero("reset");

    reset = 1'b0;
    measureEnable = 1'b1;
    model_clear();
    m_enabled = 1'b1;
    step();

    // Table rows
    for (int r = 0; r < 8; r++) begin
      repeat (rows[r].reps) run_cycle(rows[r].n, rows[r].h);
      repeat (SYNC_STAGES + 2) step();
      check("row_period", int'(period), rows[r].exp_p);
      check("row_high", int'(highTime), rows[r].exp_h);
      check("row_locked", int'(locked), int'(rows[r].exp_l && in_range(rows[r].exp_p)));
      check("row_oor", int'(outOfRange), int'(RANGE_EN && !in_range(rows[r].exp_p)));
      check("row_drain", exp_q.size(), 0);
    end

    // Stuck-low clock: lost exactly TIMEOUT cycles after the last valid
    lost_cyc = -1;
    for (int i = 0; i < TIMEOUT + 200; i++) begin
      step();
      if (lost) begin
        lost_cyc = cyc;
        break;
      end
    end
    check("lost_asserted", int'(lost), 1);
    check("lost_latency", lost_cyc - last_valid_cyc, TIMEOUT);
    check("lost_locked", int'(locked), 0);
    check("lost_oor", int'(outOfRange), int'(RANGE_EN));
    set_clk(1'b1);
    repeat (SYNC_STAGES + 3) step();
    check("lost_cleared", int'(lost), 0);
    repeat (50 - (SYNC_STAGES + 3)) step();
    set_clk(1'b0);
    repeat (50) step();
    vc = valid_count;
    run_cycle(100, 50);
    check("recover_valids", valid_count - vc, 1);
    check("recover_period", int'(period), 100);

    // Reset for one cycle in the low phase of a period
    set_clk(1'b1);
    repeat (50) step();
    set_clk(1'b0);
    repeat (20) step();
    reset = 1'b1;
    step();
    check_all_zero("midreset");
    reset = 1'b0;
    model_clear();
    exp_q.delete();
    repeat (30) step();
    vc = valid_count;
    run_cycle(100, 50);
    check("rearm_no_valid", valid_count - vc, 0);
    repeat (5) run_cycle(100, 50);
    check("rearm_locked", int'(locked), int'(in_range(100)));

    // measureEnable dropped together with a rising edge
    saved_p = int'(period);
    saved_h = int'(highTime);
    vc = valid_count;
    measureEnable = 1'b0;
    m_enabled = 1'b0;
    model_clear();
    set_clk(1'b1);
    repeat (10) step();
    check("idle_no_valid", valid_count - vc, 0);
    check("idle_locked", int'(locked), 0);
    check("idle_period_hold", int'(period), saved_p);
    check("idle_high_hold", int'(highTime), saved_h);
    measureEnable = 1'b1;
    m_enabled = 1'b1;
    repeat (40) step();
    set_clk(1'b0);
    repeat (50) step();
    repeat (3) run_cycle(100, 50);

    // Random clocks against the model
    for (int s = 0; s < 30; s++) begin
      n = $urandom_range(250, 4);
      h = $urandom_range(n - 2, 2);
      reps = $urandom_range(6, 1);
      repeat (reps) run_cycle(n, h);
    end
    repeat (SYNC_STAGES + 4) step();
    check("final_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
